// File: rtl/mmram_stage.sv
// Matching-memory RAM stage: stores the first operand of a dyadic pair,
// pairs it with its partner on a match, and passes monadic packets straight
// through.
//
// The output is a single-entry register with a valid/ready handshake on both
// sides.
module mmram_stage #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int TAG_W  = 18,
    parameter int DATA_W = 16
) (
    input  logic                        CP,
    input  logic                        MR_N,
    input  logic                        Send_in,
    output logic                        Ack_out,
    input  logic                        WR_E,
    input  logic                        DEL,
    input  logic [ADDR_W-1:0]           ADDR,
    input  logic [2+TAG_W+DATA_W-1:0]   PACKET_IN,
    output logic                        Send_out,
    input  logic                        Ack_in,
    output logic [TAG_W+2*DATA_W-1:0]   PACKET_OUT,
    output logic [ADDR_W:0]             OCC,
    output logic                        ERR
);

    localparam logic [ADDR_W:0] OCC_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OCC_ONE = (ADDR_W+1)'(1);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [TAG_W+2*DATA_W-1:0]   pkt_q, pkt_d;
    logic [ADDR_W:0]             occ_q, occ_d;
    logic                        err_q, err_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DATA_W-1:0]           mem_q [DEPTH];

    logic                        mf_s;
    logic [TAG_W-1:0]            tag_s;
    logic                        lr_s;
    logic [DATA_W-1:0]           data_s;
    logic [DATA_W-1:0]           stored_s;
    logic                        entry_valid_s;
    logic                        accept_s;
    logic                        retire_s;
    logic                        write_s;
    logic                        match_s;
    logic                        bypass_s;
    logic                        bad_s;

    assign Ack_out    = (state_q == ST_EMPTY) | Ack_in;
    assign Send_out   = (state_q == ST_FULL);
    assign PACKET_OUT = pkt_q;
    assign OCC        = occ_q;
    assign ERR        = err_q;

    // Split the incoming packet and decode what this accept does.
    // The RAM read is asynchronous, so a match sees a write from the previous edge.
    always_comb begin
        mf_s          = PACKET_IN[2+TAG_W+DATA_W-1];
        tag_s         = PACKET_IN[TAG_W+DATA_W:DATA_W+1];
        lr_s          = PACKET_IN[DATA_W];
        data_s        = PACKET_IN[DATA_W-1:0];
        stored_s      = mem_q[ADDR];
        entry_valid_s = valid_q[ADDR];
        accept_s      = Send_in & Ack_out;
        retire_s      = (state_q == ST_FULL) & Ack_in;
        write_s       = accept_s & mf_s & WR_E & ~DEL;
        match_s       = accept_s & mf_s & DEL & ~WR_E;
        bypass_s      = accept_s & ~mf_s;
        bad_s         = accept_s & mf_s & ~(WR_E ^ DEL);
    end

    // Next-state logic for the output register, entry-valid bits, occupancy and error flag.
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        occ_d   = occ_q;
        err_d   = err_q;
        valid_d = valid_q;

        if (bypass_s) begin
            state_d = ST_FULL;
            pkt_d   = {tag_s, data_s, {DATA_W{1'b0}}};
        end else if (match_s) begin
            state_d = ST_FULL;
            pkt_d   = lr_s ? {tag_s, stored_s, data_s} : {tag_s, data_s, stored_s};
        end else if (retire_s) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end

        if (write_s) begin
            valid_d[ADDR] = 1'b1;
            if (entry_valid_s) begin
                err_d = 1'b1;
            end else if (occ_q != OCC_MAX) begin
                occ_d = occ_q + OCC_ONE;
            end else begin
                occ_d = occ_q;
            end
        end else if (match_s) begin
            valid_d[ADDR] = 1'b0;
            if (!entry_valid_s) begin
                err_d = 1'b1;
            end else if (occ_q != '0) begin
                occ_d = occ_q - OCC_ONE;
            end else begin
                occ_d = occ_q;
            end
        end else if (bad_s) begin
            err_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Control and output registers; reset discards any pending packet and all entries.
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= ST_EMPTY;
            pkt_q   <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // Operand storage; contents are meaningless until the entry-valid bit is set.
    always_ff @(posedge CP) begin
        if (write_s) begin
            mem_q[ADDR] <= data_s;
        end
    end

endmodule

// File: tb/tb_mmram_stage.sv
// Bench for mmram_stage: vector table plus hand-written corner sequences,
// with a scoreboard queue checked whenever the DUT retires a packet.
module tb_mmram_stage;

    logic        CP, MR_N, Send_in, Ack_out, WR_E, DEL, Send_out, Ack_in, ERR;
    logic [5:0]  ADDR;
    logic [35:0] PACKET_IN;
    logic [49:0] PACKET_OUT;
    logic [6:0]  OCC;

    mmram_stage dut (
        .CP(CP), .MR_N(MR_N), .Send_in(Send_in), .Ack_out(Ack_out),
        .WR_E(WR_E), .DEL(DEL), .ADDR(ADDR), .PACKET_IN(PACKET_IN),
        .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT),
        .OCC(OCC), .ERR(ERR)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct {
        logic [49:0] pkt;
        logic [49:0] mask;
    } exp_t;

    typedef struct {
        logic        mf, wr, del;
        logic [5:0]  addr;
        logic [17:0] tag;
        logic        lr;
        logic [15:0] data;
        logic        exp_out;
        logic [49:0] exp_pkt;
        logic [6:0]  exp_occ;
        logic        exp_err;
    } vec_t;

    localparam logic [49:0] FULL_MASK = {50{1'b1}};

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a packet visible with Ack_in high retires on the next rising edge.
    always @(negedge CP) begin
        if (MR_N && Send_out && Ack_in) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", PACKET_OUT);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (((PACKET_OUT ^ e.pkt) & e.mask) != 50'h0) begin
                    errors++;
                    $display("FAIL output_packet: got %0h expected %0h (mask %0h)",
                             PACKET_OUT, e.pkt, e.mask);
                end
            end
            delivered++;
        end
    end

    // Offer one packet and hold Send_in high until it is accepted; push the expectation if it produces output.
    task automatic send(input logic mf, input logic wr, input logic del, input logic [5:0] addr,
                        input logic [17:0] tag, input logic lr, input logic [15:0] data,
                        input logic exp_out, input logic [49:0] exp_pkt, input logic [49:0] mask,
                        output int stalls);
        exp_t e;
        stalls    = 0;
        Send_in   = 1'b1;
        WR_E      = wr;
        DEL       = del;
        ADDR      = addr;
        PACKET_IN = {mf, tag, lr, data};
        @(negedge CP);
        while (!Ack_out && stalls < 50) begin
            stalls++;
            @(negedge CP);
        end
        if (!Ack_out) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got Ack_out=0 expected 1 within 50 cycles");
            Send_in = 1'b0;
            return;
        end
        if (exp_out) begin
            e.pkt  = exp_pkt;
            e.mask = mask;
            sb.push_back(e);
        end
        @(posedge CP);
        #1;
    endtask

    task automatic idle();
        Send_in = 1'b0;
        WR_E    = 1'b0;
        DEL     = 1'b0;
    endtask

    vec_t vecs[9];
    int   st;
    int   d0;
    exp_t eb;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 6'd3,  18'h0,     1'b0, 16'h1234, 1'b0, 50'h0,                             7'd1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 6'd3,  18'h2A5,   1'b1, 16'h00AB, 1'b1, {18'h2A5, 16'h1234, 16'h00AB},   7'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 6'd10, 18'h0,     1'b1, 16'h0007, 1'b0, 50'h0,                             7'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 6'd10, 18'h11,    1'b0, 16'h0009, 1'b1, {18'h11, 16'h0009, 16'h0007},    7'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 6'd5,  18'h3FFFF, 1'b1, 16'hBEEF, 1'b1, {18'h3FFFF, 16'hBEEF, 16'h0000}, 7'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 6'd63, 18'h0,     1'b0, 16'hAAAA, 1'b0, 50'h0,                             7'd1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 6'd0,  18'h0,     1'b0, 16'h5555, 1'b0, 50'h0,                             7'd2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 6'd63, 18'h1,     1'b1, 16'h0001, 1'b1, {18'h1, 16'hAAAA, 16'h0001},     7'd1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 6'd0,  18'h2,     1'b0, 16'h0002, 1'b1, {18'h2, 16'h0002, 16'h5555},     7'd0, 1'b0};

        MR_N = 1'b0; Ack_in = 1'b1; PACKET_IN = '0; ADDR = '0;
        idle();
        repeat (2) @(negedge CP);
        MR_N = 1'b1;
        @(posedge CP); #1;

        // Reset with stale entries, then a DEL to a freed address.
        send(1'b1, 1'b1, 1'b0, 6'd5, 18'h0, 1'b0, 16'h5A5A, 1'b0, 50'h0, FULL_MASK, st);
        send(1'b1, 1'b1, 1'b0, 6'd7, 18'h0, 1'b0, 16'h0707, 1'b0, 50'h0, FULL_MASK, st);
        idle();
        chk("occ_before_reset", OCC, 7'd2);
        MR_N = 1'b0;
        #1;
        chk("reset_occ", OCC, 7'd0);
        chk("reset_send_out", Send_out, 1'b0);
        chk("reset_err", ERR, 1'b0);
        @(negedge CP);
        MR_N = 1'b1;
        @(negedge CP);
        chk("reset_ack_out", Ack_out, 1'b1);
        @(posedge CP); #1;
        send(1'b1, 1'b0, 1'b1, 6'd5, 18'h1, 1'b1, 16'h0011, 1'b1,
             {18'h1, 16'h0000, 16'h0011}, {18'h3FFFF, 16'h0000, 16'hFFFF}, st);
        idle();
        chk("del_invalid_err", ERR, 1'b1);
        chk("del_invalid_occ", OCC, 7'd0);
        repeat (3) @(posedge CP);
        #1;

        MR_N = 1'b0;
        #1;
        chk("err_cleared_by_reset", ERR, 1'b0);
        @(negedge CP);
        MR_N = 1'b1;
        @(posedge CP); #1;

        // Table vectors, offered back to back.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].mf, vecs[i].wr, vecs[i].del, vecs[i].addr, vecs[i].tag, vecs[i].lr,
                 vecs[i].data, vecs[i].exp_out, vecs[i].exp_pkt, FULL_MASK, st);
            chk($sformatf("vec%0d_occ", i), OCC, vecs[i].exp_occ);
            chk($sformatf("vec%0d_err", i), ERR, vecs[i].exp_err);
        end
        idle();
        repeat (3) @(posedge CP);
        #1;
        chk("table_drained", sb.size(), 0);

        // Backpressure: first bypass packet held, second offered and stalled.
        Ack_in = 1'b0;
        d0 = delivered;
        send(1'b0, 1'b0, 1'b0, 6'd0, 18'h00A, 1'b0, 16'hA000, 1'b1, {18'h00A, 16'hA000, 16'h0000}, FULL_MASK, st);
        PACKET_IN = {1'b0, 18'h00B, 1'b1, 16'hB000};
        Send_in   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CP);
            chk($sformatf("bp_ack_out_c%0d", c), Ack_out, 1'b0);
            chk($sformatf("bp_send_out_c%0d", c), Send_out, 1'b1);
            chk($sformatf("bp_hold_pkt_c%0d", c), PACKET_OUT, {18'h00A, 16'hA000, 16'h0000});
        end
        @(posedge CP); #1;
        Ack_in  = 1'b1;
        eb.pkt  = {18'h00B, 16'hB000, 16'h0000};
        eb.mask = FULL_MASK;
        sb.push_back(eb);
        @(posedge CP); #1;
        send(1'b0, 1'b0, 1'b0, 6'd0, 18'h00C, 1'b0, 16'hC000, 1'b1, {18'h00C, 16'hC000, 16'h0000}, FULL_MASK, st);
        chk("bp_c_no_stall", st, 0);
        send(1'b0, 1'b0, 1'b0, 6'd0, 18'h00D, 1'b0, 16'hD000, 1'b1, {18'h00D, 16'hD000, 16'h0000}, FULL_MASK, st);
        chk("bp_d_no_stall", st, 0);
        idle();
        repeat (3) @(posedge CP);
        #1;
        chk("bp_delivered", delivered - d0, 4);
        chk("bp_drained", sb.size(), 0);

        // Fill every entry, then double write, bad decode and a match on the overwritten entry.
        for (int a = 0; a < 64; a++) begin
            send(1'b1, 1'b1, 1'b0, 6'(a), 18'h0, 1'b0, 16'(a), 1'b0, 50'h0, FULL_MASK, st);
        end
        idle();
        chk("fill_occ", OCC, 7'd64);
        chk("fill_no_output", Send_out, 1'b0);
        chk("fill_err", ERR, 1'b0);
        send(1'b1, 1'b1, 1'b0, 6'd0, 18'h0, 1'b0, 16'hCAFE, 1'b0, 50'h0, FULL_MASK, st);
        chk("double_write_err", ERR, 1'b1);
        chk("double_write_occ", OCC, 7'd64);
        send(1'b1, 1'b1, 1'b1, 6'd1, 18'h0, 1'b0, 16'h1111, 1'b0, 50'h0, FULL_MASK, st);
        idle();
        chk("bad_decode_occ", OCC, 7'd64);
        chk("bad_decode_no_output", Send_out, 1'b0);
        send(1'b1, 1'b0, 1'b1, 6'd0, 18'h3, 1'b1, 16'h0F0F, 1'b1, {18'h3, 16'hCAFE, 16'h0F0F}, FULL_MASK, st);
        idle();
        chk("match_after_fill_occ", OCC, 7'd63);
        repeat (3) @(posedge CP);
        #1;
        chk("fill_drained", sb.size(), 0);

        // Reset while a packet is held by backpressure.
        Ack_in = 1'b0;
        send(1'b0, 1'b0, 1'b0, 6'd0, 18'h77, 1'b0, 16'h1111, 1'b1, {18'h77, 16'h1111, 16'h0000}, FULL_MASK, st);
        idle();
        @(negedge CP);
        chk("mid_full", Send_out, 1'b1);
        #2;
        MR_N = 1'b0;
        #1;
        chk("mid_send_out", Send_out, 1'b0);
        chk("mid_pkt_cleared", PACKET_OUT, 50'h0);
        chk("mid_occ", OCC, 7'd0);
        chk("mid_err", ERR, 1'b0);
        sb.delete();
        d0 = delivered;
        @(negedge CP);
        MR_N   = 1'b1;
        Ack_in = 1'b1;
        repeat (5) @(posedge CP);
        #1;
        chk("mid_never_delivered", delivered - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
